contador_regressivo_m: RTL and testbench
========================================

# contador_regressivo_m

Synchronous, cascadable modulo-M down counter with 74-series-style control inputs (active-low clear, active-low load, count enables ENT/ENP). It counts in the opposite direction to the team's 74163-style up counter and gives a cascade borrow output in place of ripple carry-out. It adds an optional auto-reload of the last loaded value and a registered wrap pulse, so it can serve directly as a countdown timer or interval generator in datapaths driven by the lab FSMs.

## Interface
- N, default 4: counter width in bits; N must satisfy 2^N >= M.
- M, default 16: modulus; legal range 2..2^N.
- clock  in  1  sole clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset; highest priority.
- clr  in  1  synchronous clear, active-low.
- ld  in  1  synchronous load, active-low.
- ent  in  1  count enable, also gates brw (cascade input).
- enp  in  1  count enable, does not gate brw.
- recarga  in  1  mode: 1 = wrap to reload register, 0 = wrap to M-1.
- D  in  N  load value.
- Q  out  N  current count.
- brw  out  1  combinational borrow: ent && (Q == 0).
- zero  out  1  combinational: Q == 0.
- fim  out  1  registered one-cycle pulse, asserted the cycle after a wrap.
- R  out  N  current reload register value.

## Operation
- Priority on each posedge, first match wins:
  - reset=1: Q<=0, R<=M-1, fim<=0.
  - clr=0: Q<=0, fim<=0; R unchanged.
  - ld=0: Q<=Dsat, R<=Dsat, fim<=0. Dsat = D if D<=M-1, else M-1. Values of D at or above M are saturated and never wrap.
  - ent=1 and enp=1:
    - If Q!=0: Q<=Q-1, fim<=0.
    - If Q==0, this is a wrap: Q<=(recarga ? R : M-1), fim<=1.
  - Otherwise: Q holds, fim<=0.
- Q never leaves the range 0..M-1 after reset.
- R changes only on reset or on a load. clr does not change R.
- recarga is sampled only at the wrap edge. Changing it at any other time has no effect.
- Cascade: connect brw of stage k to ent of stage k+1. Drive enp of every stage from a common enable. The chain then forms a multi-digit down counter, so M=10 per stage gives a BCD countdown.
- brw and zero are purely combinational from Q and ent, with no register.
- If R==0 and recarga=1, the wrap holds Q at 0 and fim pulses on every enabled cycle. This is legal.

## Timing
- Load latency: 1 cycle. Q=Dsat is visible after the edge where ld=0.
- Count step: 1 cycle per enabled edge.
- fim goes high in the cycle after the wrapping edge and stays high for exactly 1 cycle, unless the next edge is also a wrap.
- brw/zero follow Q within the same cycle, with combinational delay only.
- Reset mid-count: at the next edge Q=0, R=M-1, fim=0, regardless of ld/clr/ent/enp. brw=ent after reset.
- Simultaneous events:
  - reset beats clr, which beats ld, which beats count.
  - ld=0 with ent=enp=1 loads and does not count.
  - clr=0 with ld=0 clears; R is not updated.
- Outputs right after reset: Q=0, R=M-1, fim=0, zero=1, brw=ent.

## Test plan
- N=4, M=10. Reset, then ent=enp=1, recarga=0 for 12 cycles: Q = 0,9,8,7,6,5,4,3,2,1,0,9. fim is high in the cycle where Q first shows 9 and again at the second 9. brw=1 only while Q=0.
- Load D=5 (ld=0 for 1 edge), recarga=1, count: Q = 5,4,3,2,1,0,5,4. fim pulses once after 0→5. R=5 throughout.
- Load D=13 with M=10: Q=9 and R=9 (saturation). Then clr=0 for 1 edge: Q=0, R stays 9.
- Hold tests:
  - enp=0 with Q=3: Q stays 3 for 4 cycles.
  - ent=0 with Q=0: Q stays 0 and brw=0.
  - Then ent=1: brw=1 combinationally.
- Priority: with Q=6, apply reset=1, clr=0, ld=0, D=2 together: Q=0 and R=9. Next edge with clr=0, ld=0, D=2: Q=0 and R=9.
- Two stages cascaded, M=10 each, both loaded to 0, recarga=0, common enp=1: after 1 edge (tens,units)=(9,9). After 10 more edges: (8,9). The tens stage decrements only on edges where units brw=1.

Source files
------------

// File: rtl/contador_regressivo_m.sv
// Synchronous cascadable modulo-M down counter with 74-series controls,
// optional auto-reload of the last loaded value and a registered wrap pulse.
module contador_regressivo_m #(
    parameter int N = 4,
    parameter int M = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         ld,
    input  logic         ent,
    input  logic         enp,
    input  logic         recarga,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         brw,
    output logic         zero,
    output logic         fim,
    output logic [N-1:0] R
);

    localparam logic [N-1:0] max_cnt = N'(M - 1);

    logic [N-1:0] d_sat;

    // Loads above the modulus clamp to M-1 so Q can never leave 0..M-1.
    assign d_sat = (D > max_cnt) ? max_cnt : D;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            Q   <= '0;
            R   <= max_cnt;
            fim <= 1'b0;
        end else if (!clr) begin
            Q   <= '0;
            fim <= 1'b0;
        end else if (!ld) begin
            Q   <= d_sat;
            R   <= d_sat;
            fim <= 1'b0;
        end else if (ent && enp) begin
            if (Q != '0) begin
                Q   <= Q - N'(1);
                fim <= 1'b0;
            end else begin
                // Wrap edge: recarga is only looked at here.
                Q   <= recarga ? R : max_cnt;
                fim <= 1'b1;
            end
        end else begin
            fim <= 1'b0;
        end
    end

    assign zero = (Q == '0);
    assign brw  = ent && zero;

endmodule

// File: tb/tb_contador_regressivo_m.sv
// Self-checking bench for contador_regressivo_m: scoreboard against a
// behavioural model, directed test-plan sequences and a two-stage cascade.
module tb_contador_regressivo_m;

    localparam int N = 4;
    localparam int M = 10;
    localparam logic [N-1:0] max_cnt = 4'd9;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         f;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset, clr, ld, ent, enp, recarga;
    logic [N-1:0] D, Q, R;
    logic         brw, zero, fim;

    // cascade: u0 = units, u1 = tens
    logic         c_reset, c_clr, c_ld, c_ent0, c_enp, c_rec;
    logic [N-1:0] c_d, q0, q1, r0, r1;
    logic         brw0, brw1, z0, z1, f0, f1;

    int n_vec = 0;
    int n_err = 0;

    exp_t         exp_q[$];
    logic [7:0]   casc_q[$];
    logic [N-1:0] mq, mr;
    logic         mf;

    always #5 clock = ~clock;

    contador_regressivo_m #(.N(N), .M(M)) dut (
        .clock(clock), .reset(reset), .clr(clr), .ld(ld), .ent(ent), .enp(enp),
        .recarga(recarga), .D(D), .Q(Q), .brw(brw), .zero(zero), .fim(fim), .R(R)
    );

    contador_regressivo_m #(.N(N), .M(M)) u0 (
        .clock(clock), .reset(c_reset), .clr(c_clr), .ld(c_ld), .ent(c_ent0), .enp(c_enp),
        .recarga(c_rec), .D(c_d), .Q(q0), .brw(brw0), .zero(z0), .fim(f0), .R(r0)
    );

    contador_regressivo_m #(.N(N), .M(M)) u1 (
        .clock(clock), .reset(c_reset), .clr(c_clr), .ld(c_ld), .ent(brw0), .enp(c_enp),
        .recarga(c_rec), .D(c_d), .Q(q1), .brw(brw1), .zero(z1), .fim(f1), .R(r1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance the reference model by one edge using the current inputs.
    task automatic model_step();
        logic [N-1:0] ds;
        ds = (D > max_cnt) ? max_cnt : D;
        if (reset) begin
            mq = '0; mr = max_cnt; mf = 1'b0;
        end else if (!clr) begin
            mq = '0; mf = 1'b0;
        end else if (!ld) begin
            mq = ds; mr = ds; mf = 1'b0;
        end else if (ent && enp) begin
            if (mq != '0) begin
                mq = mq - 4'd1; mf = 1'b0;
            end else begin
                mq = recarga ? mr : max_cnt; mf = 1'b1;
            end
        end else begin
            mf = 1'b0;
        end
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        model_step();
        e.q = mq; e.r = mr; e.f = mf;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check({tag, ".Q"},    32'(Q),    32'(e.q));
        check({tag, ".R"},    32'(R),    32'(e.r));
        check({tag, ".fim"},  32'(fim),  32'(e.f));
        check({tag, ".zero"}, 32'(zero), 32'(e.q == '0));
        check({tag, ".brw"},  32'(brw),  32'(ent && (e.q == '0)));
    endtask

    task automatic idle();
        reset = 1'b0; clr = 1'b1; ld = 1'b1; ent = 1'b1; enp = 1'b1; recarga = 1'b0; D = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] seq1 [11];
        logic [N-1:0] seq2 [7];
        logic [N-1:0] eu, et;
        seq1 = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        seq2 = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5, 4'd4};
        mq = '0; mr = '0; mf = 1'b0;

        c_reset = 1'b1; c_clr = 1'b1; c_ld = 1'b1; c_ent0 = 1'b1; c_enp = 1'b0;
        c_rec = 1'b0; c_d = '0;

        // Reset and post-reset state
        idle(); reset = 1'b1; ent = 1'b0;
        cycle("rst0");
        cycle("rst1");
        check("rst.Q", 32'(Q), 0);
        check("rst.R", 32'(R), 9);
        check("rst.zero", 32'(zero), 1);
        check("rst.brw_ent0", 32'(brw), 0);

        // Free count, wrap to M-1
        idle();
        for (int i = 0; i < 11; i++) begin
            cycle($sformatf("cnt%0d", i));
            check($sformatf("seq1_%0d", i), 32'(Q), 32'(seq1[i]));
            check($sformatf("seq1_fim%0d", i), 32'(fim), 32'(i == 0 || i == 10));
        end

        // Load 5, auto-reload
        ld = 1'b0; D = 4'd5; recarga = 1'b1;
        cycle("ld5");
        check("ld5.Q", 32'(Q), 5);
        ld = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle($sformatf("rl%0d", i));
            check($sformatf("seq2_%0d", i), 32'(Q), 32'(seq2[i]));
            check($sformatf("seq2_R%0d", i), 32'(R), 5);
            check($sformatf("seq2_fim%0d", i), 32'(fim), 32'(i == 5));
        end

        // Saturating load, then clear keeps R
        ld = 1'b0; D = 4'd13;
        cycle("ld13");
        check("sat.Q", 32'(Q), 9);
        check("sat.R", 32'(R), 9);
        ld = 1'b1; clr = 1'b0;
        cycle("clr");
        check("clr.Q", 32'(Q), 0);
        check("clr.R", 32'(R), 9);
        clr = 1'b1;

        // Hold with enp=0 at Q=3
        ld = 1'b0; D = 4'd3;
        cycle("ld3");
        ld = 1'b1; enp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle($sformatf("holdp%0d", i));
            check($sformatf("holdp_Q%0d", i), 32'(Q), 3);
        end

        // Hold with ent=0 at Q=0, then combinational brw
        clr = 1'b0; enp = 1'b1;
        cycle("clr2");
        clr = 1'b1; ent = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("holdt%0d", i));
            check($sformatf("holdt_brw%0d", i), 32'(brw), 0);
        end
        ent = 1'b1;
        #1;
        check("brw_comb", 32'(brw), 1);

        // Priority: reset over clr over ld
        ld = 1'b0; D = 4'd6;
        cycle("ld6");
        reset = 1'b1; clr = 1'b0; ld = 1'b0; D = 4'd2;
        cycle("prio_rst");
        check("prio_rst.Q", 32'(Q), 0);
        check("prio_rst.R", 32'(R), 9);
        reset = 1'b0;
        cycle("prio_clr");
        check("prio_clr.Q", 32'(Q), 0);
        check("prio_clr.R", 32'(R), 9);

        // R==0 with recarga: Q pinned at 0, fim every enabled edge
        idle(); ld = 1'b0; D = 4'd0;
        cycle("ld0");
        ld = 1'b1; recarga = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("r0_%0d", i));
            check($sformatf("r0_fim%0d", i), 32'(fim), 1);
        end

        // Random regression against the model
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 39) == 0);
            clr     = ($urandom_range(0, 15) != 0);
            ld      = ($urandom_range(0, 7) != 0);
            ent     = ($urandom_range(0, 3) != 0);
            enp     = ($urandom_range(0, 3) != 0);
            recarga = $urandom_range(0, 1) == 1;
            D       = 4'($urandom_range(0, 15));
            cycle($sformatf("rnd%0d", i));
        end
        idle();

        // Two-stage BCD cascade
        @(posedge clock); #1;
        c_reset = 1'b0; c_ld = 1'b0; c_d = '0;
        @(posedge clock); #1;
        check("casc_ld.units", 32'(q0), 0);
        check("casc_ld.tens", 32'(q1), 0);
        c_ld = 1'b1; c_enp = 1'b1;
        eu = '0; et = '0;
        for (int i = 1; i <= 11; i++) begin
            if (eu == '0) et = (et == '0) ? max_cnt : et - 4'd1;
            eu = (eu == '0) ? max_cnt : eu - 4'd1;
            casc_q.push_back({et, eu});
            @(posedge clock); #1;
            begin
                logic [7:0] ce;
                ce = casc_q.pop_front();
                check($sformatf("casc%0d.units", i), 32'(q0), 32'(ce[3:0]));
                check($sformatf("casc%0d.tens", i), 32'(q1), 32'(ce[7:4]));
                check($sformatf("casc%0d.brw1", i), 32'(brw1), 32'(brw0 && (ce[7:4] == '0)));
            end
            if (i == 1) check("casc_99", 32'({q1, q0}), 32'(8'h99));
            if (i == 11) check("casc_89", 32'({q1, q0}), 32'(8'h89));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
